// File: rtl/dri_stage_sequencer_if.sv
// Control, stage-table, OMP-core and pixel-stream signals of dri_stage_sequencer.
// The slave modport is the sequencer's view; master is the controller/core side.
interface dri_stage_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W     = 8,
    parameter int M_W        = 5,
    parameter int K_W        = 6,
    parameter int PIX_W      = 24
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic              cfg_we;
    logic [SW-1:0]     cfg_idx;
    logic [ADDR_W-1:0] cfg_n;
    logic [M_W-1:0]    cfg_m;
    logic [K_W-1:0]    cfg_k;

    logic              start;
    logic [SW:0]       num_stages;
    logic              abort;

    logic              core_start;
    logic [ADDR_W-1:0] core_N;
    logic [M_W-1:0]    core_M;
    logic [K_W-1:0]    core_K;
    logic              core_done;
    logic              core_pixel_we;
    logic [ADDR_W-1:0] core_pixel_addr;
    logic [PIX_W-1:0]  core_pixel_val;

    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [PIX_W-1:0]  out_val;
    logic [SW-1:0]     out_stage;

    logic              busy;
    logic              stage_done;
    logic              all_done;
    logic              err_timeout;
    logic              err_pixel;
    logic [SW-1:0]     cur_stage;
    logic [ADDR_W:0]   pix_cnt;

    modport slave (
        input  cfg_we, cfg_idx, cfg_n, cfg_m, cfg_k, start, num_stages, abort,
               core_done, core_pixel_we, core_pixel_addr, core_pixel_val,
        output core_start, core_N, core_M, core_K, out_we, out_addr, out_val, out_stage,
               busy, stage_done, all_done, err_timeout, err_pixel, cur_stage, pix_cnt
    );

    modport master (
        output cfg_we, cfg_idx, cfg_n, cfg_m, cfg_k, start, num_stages, abort,
               core_done, core_pixel_we, core_pixel_addr, core_pixel_val,
        input  core_start, core_N, core_M, core_K, out_we, out_addr, out_val, out_stage,
               busy, stage_done, all_done, err_timeout, err_pixel, cur_stage, pix_cnt
    );
endinterface

// File: rtl/dri_stage_sequencer.sv
// Runs an OMP core through a table of (N,M,K) stages and tags its pixel output by stage.
// Optional macro DRI_PIXEL_CHECK_EN adds pixel address/count checking (err_pixel).
module dri_stage_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int ADDR_W         = 8,
    parameter int M_W            = 5,
    parameter int K_W            = 6,
    parameter int PIX_W          = 24,
    parameter int GAP_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic clk,
    input  logic rst,
    dri_stage_sequencer_if.slave bus
);
    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [SW:0]     NS_L     = (SW+1)'(NUM_STAGES);
    localparam logic [ADDR_W:0] PIX_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP, S_FIN} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     cur_q, cur_d;
    logic [SW:0]       cnt_q, cnt_d;
    logic [ADDR_W:0]   pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]     wdog_q, wdog_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              err_to_q, err_to_d;
    logic              sdone_q, sdone_d;
    logic              owe_q, owe_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [PIX_W-1:0]  oval_q, oval_d;
    logic [SW-1:0]     ostage_q, ostage_d;

    logic [ADDR_W-1:0] tbl_n_q [NUM_STAGES];
    logic [ADDR_W-1:0] tbl_n_d [NUM_STAGES];
    logic [M_W-1:0]    tbl_m_q [NUM_STAGES];
    logic [M_W-1:0]    tbl_m_d [NUM_STAGES];
    logic [K_W-1:0]    tbl_k_q [NUM_STAGES];
    logic [K_W-1:0]    tbl_k_d [NUM_STAGES];

    logic              run_phase;
    logic [ADDR_W-1:0] core_n;

    // The table is frozen outside IDLE, so the core parameters hold through RUN.
    assign run_phase = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign core_n    = run_phase ? tbl_n_q[cur_q] : '0;

    assign bus.core_start  = (state_q == S_LAUNCH);
    assign bus.core_N      = core_n;
    assign bus.core_M      = run_phase ? tbl_m_q[cur_q] : '0;
    assign bus.core_K      = run_phase ? tbl_k_q[cur_q] : '0;
    assign bus.out_we      = owe_q;
    assign bus.out_addr    = oaddr_q;
    assign bus.out_val     = oval_q;
    assign bus.out_stage   = ostage_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.stage_done  = sdone_q;
    assign bus.all_done    = (state_q == S_FIN) && !bus.abort;
    assign bus.err_timeout = err_to_q;
    assign bus.cur_stage   = cur_q;
    assign bus.pix_cnt     = pix_cnt_q;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        pix_cnt_d = pix_cnt_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        err_to_d  = err_to_q;
        sdone_d   = 1'b0;
        owe_d     = 1'b0;
        oaddr_d   = oaddr_q;
        oval_d    = oval_q;
        ostage_d  = ostage_q;
        tbl_n_d   = tbl_n_q;
        tbl_m_d   = tbl_m_q;
        tbl_k_d   = tbl_k_q;

        // Abort cancels everything in flight, including a same-cycle pixel or core_done.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cfg_we && ({1'b0, bus.cfg_idx} < NS_L)) begin
                        tbl_n_d[bus.cfg_idx] = bus.cfg_n;
                        tbl_m_d[bus.cfg_idx] = bus.cfg_m;
                        tbl_k_d[bus.cfg_idx] = bus.cfg_k;
                    end
                    if (bus.start) begin
                        cnt_d    = (bus.num_stages > NS_L) ? NS_L : bus.num_stages;
                        cur_d    = '0;
                        err_to_d = 1'b0;
                        state_d  = (cnt_d == '0) ? S_FIN : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    pix_cnt_d = '0;
                    wdog_d    = '0;
                    state_d   = S_RUN;
                end
                S_RUN: begin
                    if (bus.core_pixel_we) begin
                        owe_d    = 1'b1;
                        oaddr_d  = bus.core_pixel_addr;
                        oval_d   = bus.core_pixel_val;
                        ostage_d = cur_q;
                        if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                    if (bus.core_done) begin
                        sdone_d = 1'b1;
                        if ({1'b0, cur_q} == cnt_q - 1'b1) begin
                            state_d = S_FIN;
                        end else begin
                            cur_d   = cur_q + 1'b1;
                            gap_d   = '0;
                            state_d = (GAP_CYCLES == 0) ? S_LAUNCH : S_GAP;
                        end
                    end else if (wdog_q == TO_LAST) begin
                        err_to_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) state_d = S_LAUNCH;
                    else                   gap_d   = gap_q + 1'b1;
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            pix_cnt_q <= '0;
            wdog_q    <= '0;
            gap_q     <= '0;
            err_to_q  <= 1'b0;
            sdone_q   <= 1'b0;
            owe_q     <= 1'b0;
            oaddr_q   <= '0;
            oval_q    <= '0;
            ostage_q  <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                tbl_n_q[i] <= '0;
                tbl_m_q[i] <= '0;
                tbl_k_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            pix_cnt_q <= pix_cnt_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            err_to_q  <= err_to_d;
            sdone_q   <= sdone_d;
            owe_q     <= owe_d;
            oaddr_q   <= oaddr_d;
            oval_q    <= oval_d;
            ostage_q  <= ostage_d;
            tbl_n_q   <= tbl_n_d;
            tbl_m_q   <= tbl_m_d;
            tbl_k_q   <= tbl_k_d;
        end
    end

`ifdef DRI_PIXEL_CHECK_EN
    logic err_px_q, err_px_d;

    // pix_cnt_d already includes a pixel arriving together with core_done.
    always_comb begin
        err_px_d = err_px_q;
        if (state_q == S_IDLE && bus.start) begin
            err_px_d = 1'b0;
        end else if (state_q == S_RUN && !bus.abort) begin
            if (bus.core_pixel_we && (bus.core_pixel_addr > core_n)) err_px_d = 1'b1;
            if (bus.core_done && (pix_cnt_d != ({1'b0, core_n} + 1'b1))) err_px_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_px_q <= 1'b0;
        else     err_px_q <= err_px_d;
    end

    assign bus.err_pixel = err_px_q;
`else
    assign bus.err_pixel = 1'b0;
`endif
endmodule

// File: tb/tb_dri_stage_sequencer.sv
// Directed bench for dri_stage_sequencer: a scripted OMP core drives stages, a negedge
// monitor counts pulses and tagged pixels, and each test task checks its own results.
module tb_dri_stage_sequencer;
    localparam int NS = 4, AW = 8, MW = 5, KW = 6, PW = 24, GAP = 3, TO = 100, SW = 2;
`ifdef DRI_PIXEL_CHECK_EN
    localparam bit PX_CHK = 1'b1;
`else
    localparam bit PX_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    dri_stage_sequencer_if #(.NUM_STAGES(NS), .ADDR_W(AW), .M_W(MW), .K_W(KW), .PIX_W(PW)) bus();

    dri_stage_sequencer #(
        .NUM_STAGES(NS), .ADDR_W(AW), .M_W(MW), .K_W(KW), .PIX_W(PW),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Monitor: only ever counts upward; tests take snapshots and compare deltas.
    int cyc = 0, n_start = 0, n_sdone = 0, n_adone = 0, t_sdone = 0, gap_meas = 0;
    int n_out [NS] = '{default: 0};
    logic [PW-1:0] last_val = '0;

    always @(negedge clk) begin
        cyc++;
        if (bus.out_we) begin
            n_out[bus.out_stage]++;
            last_val = bus.out_val;
        end
        if (bus.stage_done) begin
            n_sdone++;
            t_sdone = cyc;
        end
        if (bus.core_start) begin
            n_start++;
            gap_meas = cyc - t_sdone;
        end
        if (bus.all_done) n_adone++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation time limit");
    end

    task automatic cfg_write(input int idx, input int n, input int m, input int k);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = SW'(idx);
        bus.cfg_n   = AW'(n);
        bus.cfg_m   = MW'(m);
        bus.cfg_k   = KW'(k);
        @(negedge clk);
        bus.cfg_we  = 1'b0;
    endtask

    task automatic do_start(input int ns);
        bus.start      = 1'b1;
        bus.num_stages = (SW+1)'(ns);
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.core_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Scripted core: pixels 0..npix-1 (optionally one bad address), then core_done.
    task automatic core_stage(input int npix, input bit same, input int bad_at, input int sid,
                              output bit ok, output logic [AW-1:0] n, output logic [MW-1:0] m,
                              output logic [KW-1:0] k, output logic [SW-1:0] cs,
                              output logic [AW-1:0] n_end);
        n = '0; m = '0; k = '0; cs = '0; n_end = '0;
        wait_start(ok);
        if (!ok) return;
        n  = bus.core_N;
        m  = bus.core_M;
        k  = bus.core_K;
        cs = bus.cur_stage;
        @(negedge clk);
        for (int p = 0; p < npix; p++) begin
            bus.core_pixel_we   = 1'b1;
            bus.core_pixel_addr = (p == bad_at) ? AW'(20) : AW'(p);
            bus.core_pixel_val  = PW'(sid * 4096 + p);
            bus.core_done       = same && (p == npix - 1);
            @(negedge clk);
        end
        bus.core_pixel_we = 1'b0;
        bus.core_done     = 1'b0;
        n_end = bus.core_N;
        if (!same) begin
            bus.core_done = 1'b1;
            @(negedge clk);
            bus.core_done = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.core_start, bus.stage_done, bus.all_done} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.busy, bus.core_start, bus.stage_done, bus.all_done});
        end
        total++;
        if ({bus.core_N, bus.core_M, bus.core_K} !== '0) begin
            bad++; $display("FAIL reset_core got=%0h exp=0", {bus.core_N, bus.core_M, bus.core_K});
        end
        total++;
        if ({bus.out_we, bus.out_addr, bus.out_val, bus.out_stage} !== '0) begin
            bad++; $display("FAIL reset_out got=%0h exp=0", {bus.out_we, bus.out_addr, bus.out_val, bus.out_stage});
        end
        total++;
        if ({bus.err_timeout, bus.err_pixel, bus.cur_stage, bus.pix_cnt} !== '0) begin
            bad++; $display("FAIL reset_status got=%0h exp=0", {bus.err_timeout, bus.err_pixel, bus.cur_stage, bus.pix_cnt});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_two_stage();
        int o0, o1, st, sd, ad;
        bit ok0, ok1;
        logic [AW-1:0] n0, n1, ne0, ne1;
        logic [MW-1:0] m0, m1;
        logic [KW-1:0] k0, k1;
        logic [SW-1:0] c0, c1;
        cfg_write(0, 15, 1, 4);
        cfg_write(1, 63, 7, 16);
        repeat (2) @(negedge clk);
        o0 = n_out[0]; o1 = n_out[1]; st = n_start; sd = n_sdone; ad = n_adone;
        // Stray pixels during IDLE and LAUNCH must be dropped.
        bus.core_pixel_we   = 1'b1;
        bus.core_pixel_addr = '0;
        @(negedge clk);
        do_start(2);
        core_stage(16, 1'b0, -1, 0, ok0, n0, m0, k0, c0, ne0);
        core_stage(64, 1'b0, -1, 1, ok1, n1, m1, k1, c1, ne1);
        repeat (3) @(negedge clk);
        total++;
        if ({ok0, ok1} !== 2'b11) begin bad++; $display("FAIL two_launch got=%b exp=11", {ok0, ok1}); end
        total++;
        if ({n0, m0, k0, c0} !== {8'd15, 5'd1, 6'd4, 2'd0}) begin
            bad++; $display("FAIL two_cfg0 got=%0d/%0d/%0d/%0d exp=15/1/4/0", n0, m0, k0, c0);
        end
        total++;
        if ({n1, m1, k1, c1} !== {8'd63, 5'd7, 6'd16, 2'd1}) begin
            bad++; $display("FAIL two_cfg1 got=%0d/%0d/%0d/%0d exp=63/7/16/1", n1, m1, k1, c1);
        end
        total++;
        if ({ne0, ne1} !== {8'd15, 8'd63}) begin bad++; $display("FAIL two_n_stable got=%0d/%0d exp=15/63", ne0, ne1); end
        total++;
        if (n_start - st !== 2) begin bad++; $display("FAIL two_starts got=%0d exp=2", n_start - st); end
        total++;
        if ((n_out[0] - o0 !== 16) || (n_out[1] - o1 !== 64)) begin
            bad++; $display("FAIL two_pixels got=%0d/%0d exp=16/64", n_out[0] - o0, n_out[1] - o1);
        end
        total++;
        if ((n_sdone - sd !== 2) || (n_adone - ad !== 1)) begin
            bad++; $display("FAIL two_done got=%0d/%0d exp=2/1", n_sdone - sd, n_adone - ad);
        end
        total++;
        if (gap_meas !== GAP) begin bad++; $display("FAIL two_gap got=%0d exp=%0d", gap_meas, GAP); end
        total++;
        if (bus.pix_cnt !== 9'd64) begin bad++; $display("FAIL two_pixcnt got=%0d exp=64", bus.pix_cnt); end
        total++;
        if (last_val !== PW'(4096 + 63)) begin bad++; $display("FAIL two_lastval got=%0h exp=%0h", last_val, 4096 + 63); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL two_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_timeout();
        int sd, ad;
        sd = n_sdone; ad = n_adone;
        do_start(1);
        total++;
        if (bus.core_start !== 1'b1) begin bad++; $display("FAIL to_launch got=%b exp=1", bus.core_start); end
        for (int k = 1; k <= TO; k++) @(negedge clk);
        total++;
        if ({bus.busy, bus.err_timeout} !== 2'b10) begin
            bad++; $display("FAIL to_before got=%b exp=10", {bus.busy, bus.err_timeout});
        end
        @(negedge clk);
        total++;
        if ({bus.busy, bus.err_timeout} !== 2'b01) begin
            bad++; $display("FAIL to_fire got=%b exp=01", {bus.busy, bus.err_timeout});
        end
        repeat (3) @(negedge clk);
        total++;
        if ((n_sdone != sd) || (n_adone != ad)) begin
            bad++; $display("FAIL to_nodone got=%0d/%0d exp=0/0", n_sdone - sd, n_adone - ad);
        end
    endtask

    task automatic test_zero_stages();
        int st;
        bit ok;
        logic [AW-1:0] n, ne;
        logic [MW-1:0] m;
        logic [KW-1:0] k;
        logic [SW-1:0] c;
        st = n_start;
        do_start(0);
        total++;
        if ({bus.all_done, bus.busy, bus.err_timeout} !== 3'b110) begin
            bad++; $display("FAIL zero_fin got=%b exp=110", {bus.all_done, bus.busy, bus.err_timeout});
        end
        cfg_write(0, 99, 9, 9);
        total++;
        if ({bus.all_done, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL zero_idle got=%b exp=00", {bus.all_done, bus.busy});
        end
        total++;
        if (n_start != st) begin bad++; $display("FAIL zero_nostart got=%0d exp=0", n_start - st); end
        do_start(1);
        core_stage(16, 1'b0, -1, 0, ok, n, m, k, c, ne);
        total++;
        if ({ok, n, m, k} !== {1'b1, 8'd15, 5'd1, 6'd4}) begin
            bad++; $display("FAIL zero_table got=%0d/%0d/%0d exp=15/1/4", n, m, k);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        int st, sd, ad, o0;
        bit ok, ok1;
        logic [AW-1:0] n, ne;
        logic [MW-1:0] m;
        logic [KW-1:0] k;
        logic [SW-1:0] c;
        st = n_start; sd = n_sdone; ad = n_adone;
        do_start(2);
        core_stage(16, 1'b0, -1, 0, ok, n, m, k, c, ne);
        wait_start(ok1);
        for (int i = 1; i <= 5; i++) @(negedge clk);
        bus.abort     = 1'b1;
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.core_done = 1'b0;
        total++;
        if ({ok, ok1, bus.busy} !== 3'b110) begin
            bad++; $display("FAIL abort_idle got=%b exp=110", {ok, ok1, bus.busy});
        end
        repeat (10) @(negedge clk);
        total++;
        if ((n_start - st !== 2) || (n_sdone - sd !== 1) || (n_adone != ad)) begin
            bad++; $display("FAIL abort_quiet got=%0d/%0d/%0d exp=2/1/0", n_start - st, n_sdone - sd, n_adone - ad);
        end
        ad = n_adone; o0 = n_out[0];
        do_start(2);
        core_stage(16, 1'b0, -1, 0, ok, n, m, k, c, ne);
        core_stage(64, 1'b0, -1, 1, ok1, n, m, k, c, ne);
        repeat (3) @(negedge clk);
        total++;
        if ({ok, ok1, n_adone - ad, n_out[0] - o0} !== {2'b11, 32'd1, 32'd16}) begin
            bad++; $display("FAIL abort_restart got=%b/%0d/%0d exp=11/1/16", {ok, ok1}, n_adone - ad, n_out[0] - o0);
        end
    endtask

    task automatic test_same_cycle();
        int ad, o0;
        bit ok;
        logic [AW-1:0] n, ne;
        logic [MW-1:0] m;
        logic [KW-1:0] k;
        logic [SW-1:0] c;
        ad = n_adone; o0 = n_out[0];
        do_start(1);
        core_stage(16, 1'b1, -1, 0, ok, n, m, k, c, ne);
        total++;
        if ({ok, bus.out_we, bus.stage_done, bus.out_addr} !== {3'b111, 8'd15}) begin
            bad++; $display("FAIL same_last got=%b/%0d exp=111/15", {ok, bus.out_we, bus.stage_done}, bus.out_addr);
        end
        total++;
        if (bus.pix_cnt !== 9'd16) begin bad++; $display("FAIL same_pixcnt got=%0d exp=16", bus.pix_cnt); end
        repeat (3) @(negedge clk);
        total++;
        if ({n_adone - ad, n_out[0] - o0} !== {32'd1, 32'd16}) begin
            bad++; $display("FAIL same_counts got=%0d/%0d exp=1/16", n_adone - ad, n_out[0] - o0);
        end
        total++;
        if (bus.err_pixel !== 1'b0) begin bad++; $display("FAIL same_errpix got=%b exp=0", bus.err_pixel); end
    endtask

    task automatic test_pixel_check();
        int o0;
        bit ok;
        logic [AW-1:0] n, ne;
        logic [MW-1:0] m;
        logic [KW-1:0] k;
        logic [SW-1:0] c;
        o0 = n_out[0];
        do_start(1);
        core_stage(17, 1'b0, 5, 0, ok, n, m, k, c, ne);
        repeat (3) @(negedge clk);
        total++;
        if ({ok, n_out[0] - o0, bus.pix_cnt} !== {1'b1, 32'd17, 9'd17}) begin
            bad++; $display("FAIL pix_forward got=%0d/%0d exp=17/17", n_out[0] - o0, bus.pix_cnt);
        end
        total++;
        if (bus.err_pixel !== PX_CHK) begin bad++; $display("FAIL pix_err got=%b exp=%b", bus.err_pixel, PX_CHK); end
    endtask

    task automatic test_reset_midrun();
        int o0;
        bit ok;
        o0 = n_out[0];
        do_start(1);
        wait_start(ok);
        @(negedge clk);
        bus.core_pixel_we   = 1'b1;
        bus.core_pixel_addr = 8'd3;
        #1 rst = 1'b1;
        #1;
        total++;
        if ({ok, bus.busy, bus.out_we} !== 3'b100) begin
            bad++; $display("FAIL rst_async got=%b exp=100", {ok, bus.busy, bus.out_we});
        end
        bus.core_pixel_we = 1'b0;
        @(negedge clk);
        total++;
        if ((n_out[0] != o0) || (bus.out_we !== 1'b0)) begin
            bad++; $display("FAIL rst_inflight got=%0d exp=0", n_out[0] - o0);
        end
        rst = 1'b0;
        @(negedge clk);
        do_start(1);
        total++;
        if ({bus.core_start, bus.core_N} !== {1'b1, 8'd0}) begin
            bad++; $display("FAIL rst_table got=%b/%0d exp=1/0", bus.core_start, bus.core_N);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_n = '0; bus.cfg_m = '0; bus.cfg_k = '0;
        bus.start = 1'b0; bus.num_stages = '0; bus.abort = 1'b0;
        bus.core_done = 1'b0; bus.core_pixel_we = 1'b0; bus.core_pixel_addr = '0; bus.core_pixel_val = '0;
        test_reset();
        test_two_stage();
        test_timeout();
        test_zero_stages();
        test_abort();
        test_same_cycle();
        test_pixel_check();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dri_stage_sequencer.md
DRI_STAGE_SEQUENCER -- requirements
Module: dri_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of stage-table entries, 1..8.
REQ-002 Parameter ADDR_W, default 8: pixel address / N width; frames up to 2^ADDR_W pixels.
REQ-003 Parameter M_W, default 5; K_W, default 6: widths of measurement-row count and sparsity limit.
REQ-004 Parameter PIX_W, default 24: pixel value width.
REQ-005 Parameter GAP_CYCLES, default 50; TIMEOUT_CYCLES, default 2^20: inter-stage idle cycles; per-stage watchdog limit.
REQ-006 Derived SW = max(1, clog2(NUM_STAGES)): stage index width.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 cfg_we  in  1; cfg_idx  in  SW; cfg_n  in  ADDR_W; cfg_m  in  M_W; cfg_k  in  K_W: stage-table write port.
REQ-010 start  in  1; num_stages  in  SW+1; abort  in  1: run request, active stage count, abort request.
REQ-011 core_start  out  1; core_N  out  ADDR_W; core_M  out  M_W; core_K  out  K_W: OMP core control.
REQ-012 core_done  in  1; core_pixel_we  in  1; core_pixel_addr  in  ADDR_W; core_pixel_val  in  PIX_W: OMP core results.
REQ-013 out_we  out  1; out_addr  out  ADDR_W; out_val  out  PIX_W; out_stage  out  SW: tagged pixel stream.
REQ-014 busy, stage_done, all_done, err_timeout, err_pixel  out  1 each; cur_stage  out  SW; pix_cnt  out  ADDR_W+1.

Function
REQ-015 FSM states IDLE, LAUNCH, RUN, GAP, FIN; one-hot or binary at implementer's choice.
REQ-016 Table write accepted only in IDLE when cfg_we=1 and cfg_idx<NUM_STAGES; otherwise ignored.
REQ-017 IDLE: start=1 latches num_stages (clamped to NUM_STAGES), clears errors, cur_stage=0; count 0 -> FIN next cycle, core never started; else -> LAUNCH.
REQ-018 LAUNCH: core_N/M/K driven from table[cur_stage], core_start=1 for exactly this one cycle, pix_cnt=0, watchdog=0; -> RUN.
REQ-019 core_N/M/K stay stable from LAUNCH through end of RUN.
REQ-020 RUN: core_pixel_we forwarded to out_* with one-cycle registered latency, out_stage=cur_stage; pix_cnt increments per accepted pixel, saturating at 2^ADDR_W.
REQ-021 RUN: core_done=1 -> stage_done pulse one cycle; if cur_stage=count-1 -> FIN, else cur_stage+1 and -> GAP.
REQ-022 Pixel and core_done in the same cycle: pixel still forwarded and counted.
REQ-023 core_pixel_we outside RUN is dropped (no out_we).
REQ-024 GAP: counts GAP_CYCLES cycles, then -> LAUNCH; GAP_CYCLES=0 -> LAUNCH next cycle.
REQ-025 Watchdog: TIMEOUT_CYCLES cycles in RUN without core_done -> err_timeout=1 (sticky until next start), -> IDLE, no all_done.
REQ-026 FIN: all_done=1 for one cycle, -> IDLE.
REQ-027 busy=1 in every state except IDLE; start while busy ignored.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle, no stage_done/all_done; abort has priority over core_done and timeout.

Reset
REQ-029 rst asserted: state IDLE; all outputs 0; cur_stage, pix_cnt, counters 0; stage table entries 0.
REQ-030 rst mid-run takes effect asynchronously; the in-flight pixel is not emitted.

Configuration
REQ-031 Macro DRI_PIXEL_CHECK_EN defined: err_pixel (sticky until next start) set when a RUN pixel has core_pixel_addr>core_N (pixel still forwarded) or when core_done arrives with pix_cnt != core_N+1.
REQ-032 DRI_PIXEL_CHECK_EN undefined: no check logic; err_pixel tied 0.

Verification
REQ-033 Table {0:(N15,M1,K4),1:(N63,M7,K16)}, start num_stages=2, core model writes 16 then 64 pixels -> core_start twice, out_stage 0 for 16 pixels then 1 for 64, two stage_done, one all_done, GAP_CYCLES cycles between stages.
REQ-034 Core never asserts core_done, TIMEOUT_CYCLES=100 -> err_timeout=1 at RUN cycle 100, busy=0, all_done never asserted.
REQ-035 abort on RUN cycle 5 of stage 1 -> IDLE next cycle, no further core_start, re-start runs normally from stage 0.
REQ-036 num_stages=0 -> all_done one cycle after start, core_start never asserted; cfg_we during busy leaves table unchanged.
REQ-037 With DRI_PIXEL_CHECK_EN, N=15, core writes addr 20 and 17 pixels total -> err_pixel=1; without the macro err_pixel stays 0.
REQ-038 Pixel and core_done same cycle on last pixel -> pixel appears on out_we, pix_cnt=N+1, stage_done asserted.
